key_conditioner: RTL

Input-conditioning stage directly upstream of the traffic-light top level. Takes the raw board pushbuttons (plus, sub) and the 2-bit mode switch, synchronises them to clk, debounces them, and produces clean single-cycle press pulses with hold-to-repeat plus a stable mode code. Outputs feed the top level's plus/sub count-setting logic and its run/night/set-RG/set-Y mode decode in place of the raw pins.

---
 rtl/key_conditioner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and pulse-shapes two pushbuttons plus a 2-bit mode switch.
// Latency: clean raw edge -> debounced level after 2+DEB_CYC cycles, pulse/state_change one cycle later.
// Backpressure: none; outputs are single-cycle strobes plus a held mode level, consumer must keep up.
//
// Ports:
//   clk, rst                : clock and synchronous active-high reset
//   key_plus_in, key_sub_in : raw asynchronous buttons (pressed level set by KEY_ACTIVE_LOW)
//   key_state_in            : raw asynchronous 2-bit mode switch
//   plus_pulse, sub_pulse   : one-cycle press / auto-repeat strobes
//   key_state_out           : debounced mode (00 run, 01 night, 10 set RG, 11 set Y)
//   state_change            : one-cycle strobe the cycle after key_state_out updates
// Build option: define KEY_AUTOREPEAT_EN for hold-to-repeat; otherwise a press gives exactly one pulse.
module key_conditioner #(
  parameter int unsigned DEB_CYC        = 240000,
  parameter int unsigned RPT_DLY_CYC    = 6000000,
  parameter int unsigned RPT_CYC        = 1200000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_plus_in,
  input  logic       key_sub_in,
  input  logic [1:0] key_state_in,
  output logic       plus_pulse,
  output logic       sub_pulse,
  output logic [1:0] key_state_out,
  output logic       state_change
);

  // Raw level of a released button; synchroniser flops reset to it so a
  // button held through reset is seen as a fresh press afterwards.
  localparam logic KEY_REL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  // Largest count any counter ever needs; counters stop here instead of wrapping.
  localparam int unsigned CNT_CAP_I =
    (DEB_CYC > RPT_DLY_CYC) ? ((DEB_CYC > RPT_CYC) ? DEB_CYC : RPT_CYC)
                            : ((RPT_DLY_CYC > RPT_CYC) ? RPT_DLY_CYC : RPT_CYC);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CNT_CAP_I);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------- synchronisers ----------------
  logic [1:0] key_s1, key_s2;          // bit0 plus, bit1 sub, raw polarity
  logic [1:0] mode_s1, mode_s2, mode_s3;
  logic [1:0] key_sync;                // 1 = pressed

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= {2{KEY_REL}};
      key_s2  <= {2{KEY_REL}};
      mode_s1 <= 2'b00;
      mode_s2 <= 2'b00;
      mode_s3 <= 2'b00;
    end else begin
      key_s1  <= {key_sub_in, key_plus_in};
      key_s2  <= key_s1;
      mode_s1 <= key_state_in;
      mode_s2 <= mode_s1;
      mode_s3 <= mode_s2;
    end
  end

  assign key_sync = KEY_ACTIVE_LOW ? ~key_s2 : key_s2;

  // ---------------- button debounce ----------------
  logic [1:0]       key_deb, key_deb_q;
  logic [CNT_W-1:0] key_deb_cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      key_deb   <= 2'b00;
      key_deb_q <= 2'b00;
      for (int i = 0; i < 2; i++) key_deb_cnt[i] <= '0;
    end else begin
      key_deb_q <= key_deb;
      for (int i = 0; i < 2; i++) begin
        if (key_sync[i] == key_deb[i]) begin
          key_deb_cnt[i] <= '0;
        end else if (key_deb_cnt[i] >= DEB_LAST) begin
          key_deb[i]     <= key_sync[i];
          key_deb_cnt[i] <= '0;
        end else if (key_deb_cnt[i] != CNT_CAP) begin
          key_deb_cnt[i] <= key_deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // ---------------- mode word debounce ----------------
  // The run restarts whenever the synced word itself changes, so an
  // update only happens after one value has been steady for DEB_CYC cycles.
  logic [CNT_W-1:0] mode_cnt, mode_run;
  logic             mode_upd;

  assign mode_run = (mode_s2 != mode_s3) ? '0 : mode_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state_out <= 2'b00;
      mode_cnt      <= '0;
      mode_upd      <= 1'b0;
      state_change  <= 1'b0;
    end else begin
      mode_upd     <= 1'b0;
      state_change <= mode_upd;
      if (mode_s2 == key_state_out) begin
        mode_cnt <= '0;
      end else if (mode_run >= DEB_LAST) begin
        key_state_out <= mode_s2;
        mode_cnt      <= '0;
        mode_upd      <= 1'b1;
      end else if (mode_run != CNT_CAP) begin
        mode_cnt <= mode_run + CNT_ONE;
      end
    end
  end

  // ---------------- button FSMs ----------------
`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(RPT_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST     = CNT_W'(RPT_CYC - 1);
  logic [CNT_W-1:0] rpt_cnt_q [2];
  logic [CNT_W-1:0] rpt_cnt_d [2];
`else
  typedef enum logic {IDLE, HELD} btn_state_t;
`endif

  btn_state_t st_q [2];
  btn_state_t st_d [2];
  logic [1:0] pulse_d;
  logic [1:0] key_press;
  logic       lockout;

  // Only a debounced rising edge starts a press; a button whose edge lands
  // during lockout therefore never gets an initial pulse afterwards.
  assign key_press = key_deb & ~key_deb_q;
  assign lockout   = &key_deb;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]    = st_q[i];
      pulse_d[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_cnt_d[i] = rpt_cnt_q[i];
`endif
      if (!key_deb[i]) begin
        st_d[i] = IDLE;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_d[i] = '0;
`endif
      end else if (!lockout) begin
        case (st_q[i])
          IDLE: begin
            if (key_press[i]) begin
              pulse_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              st_d[i]      = DELAY;
              rpt_cnt_d[i] = '0;
`else
              st_d[i] = HELD;
`endif
            end
          end
`ifdef KEY_AUTOREPEAT_EN
          DELAY: begin
            if (rpt_cnt_q[i] >= RPT_DLY_LAST) begin
              pulse_d[i]   = 1'b1;
              rpt_cnt_d[i] = '0;
              st_d[i]      = REPEAT;
            end else if (rpt_cnt_q[i] != CNT_CAP) begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
            end
          end
          REPEAT: begin
            if (rpt_cnt_q[i] >= RPT_LAST) begin
              pulse_d[i]   = 1'b1;
              rpt_cnt_d[i] = '0;
            end else if (rpt_cnt_q[i] != CNT_CAP) begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
            end
          end
`else
          HELD: begin
            st_d[i] = HELD;
          end
`endif
          default: st_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plus_pulse <= 1'b0;
      sub_pulse  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_q[i] <= '0;
`endif
      end
    end else begin
      plus_pulse <= pulse_d[0];
      sub_pulse  <= pulse_d[1];
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= st_d[i];
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_q[i] <= rpt_cnt_d[i];
`endif
      end
    end
  end

endmodule
